// File: rtl/rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : rtc_timekeeper
// Description : Real-time clock fed by the 1 kHz divided clock. Edge-detects
//               tick_in, prescales it to a 1 ms strobe, keeps hh:mm:ss.mmm
//               and runs a millisecond countdown timer with a level
//               interrupt and an ack handshake.
//               Optional alarm (hour:minute match) when RTC_ALARM_EN is
//               defined; otherwise alarm_irq is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_timekeeper #(
    parameter int TICKS_PER_MS = 1,
    parameter int TMR_W        = 16
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             hold,
    input  logic             set_en,
    input  logic [4:0]       set_hour,
    input  logic [5:0]       set_min,
    input  logic [5:0]       set_sec,
    input  logic             tmr_load,
    input  logic [TMR_W-1:0] tmr_val,
    input  logic             tmr_stop,
    input  logic             tmr_ack,
    input  logic [4:0]       alarm_hour,
    input  logic [5:0]       alarm_min,
    output logic [9:0]       ms,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hour,
    output logic             day_wrap,
    output logic [TMR_W-1:0] tmr_count,
    output logic             tmr_busy,
    output logic             tmr_irq,
    output logic             alarm_irq
);

    localparam logic [7:0] PCNT_LAST = 8'(TICKS_PER_MS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } tmr_state_t;

    logic             tick_d;
    logic             rise;
    logic             advance;
    logic [7:0]       pcnt;
    logic             ms_strobe;

    tmr_state_t       state;
    tmr_state_t       state_nxt;
    logic [TMR_W-1:0] cnt_nxt;
    logic             irq_nxt;

    // A held-high level produces a single rise; hold discards the event.
    assign rise      = tick_in & ~tick_d;
    assign advance   = rise & ~hold;
    assign ms_strobe = advance && (pcnt == PCNT_LAST);

    // Edge-detect register and tick prescaler.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            tick_d <= 1'b0;
            pcnt   <= 8'd0;
        end else begin
            tick_d <= tick_in;
            if (set_en) begin
                pcnt <= 8'd0;
            end else if (advance) begin
                pcnt <= (pcnt == PCNT_LAST) ? 8'd0 : pcnt + 8'd1;
            end
        end
    end

    // Time-of-day cascade; a load beats a coincident ms strobe.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            ms       <= 10'd0;
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day_wrap <= 1'b0;
        end else begin
            day_wrap <= 1'b0;
            if (set_en) begin
                ms   <= 10'd0;
                sec  <= (set_sec  <= 6'd59) ? set_sec  : 6'd0;
                min  <= (set_min  <= 6'd59) ? set_min  : 6'd0;
                hour <= (set_hour <= 5'd23) ? set_hour : 5'd0;
            end else if (ms_strobe) begin
                if (ms == 10'd999) begin
                    ms <= 10'd0;
                    if (sec == 6'd59) begin
                        sec <= 6'd0;
                        if (min == 6'd59) begin
                            min <= 6'd0;
                            if (hour == 5'd23) begin
                                hour     <= 5'd0;
                                day_wrap <= 1'b1;
                            end else begin
                                hour <= hour + 5'd1;
                            end
                        end else begin
                            min <= min + 6'd1;
                        end
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end else begin
                    ms <= ms + 10'd1;
                end
            end
        end
    end

    // Timer state register with registered count, busy and interrupt.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr_count <= '0;
            tmr_irq   <= 1'b0;
            tmr_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr_count <= cnt_nxt;
            tmr_irq   <= irq_nxt;
            tmr_busy  <= (state_nxt == RUN);
        end
    end

    // Timer next-state: load > stop > ack > decrement.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = tmr_count;
        irq_nxt   = tmr_irq;
        if (tmr_load) begin
            cnt_nxt = tmr_val;
            if (tmr_val != '0) begin
                state_nxt = RUN;
                irq_nxt   = 1'b0;
            end else begin
                state_nxt = EXPIRED;
                irq_nxt   = 1'b1;
            end
        end else if (tmr_stop && (state == RUN)) begin
            state_nxt = IDLE;
        end else if (tmr_ack && (state == EXPIRED)) begin
            state_nxt = IDLE;
            irq_nxt   = 1'b0;
        end else if ((state == RUN) && ms_strobe) begin
            cnt_nxt = tmr_count - 1'b1;
            if (tmr_count == TMR_W'(1)) begin
                state_nxt = EXPIRED;
                irq_nxt   = 1'b1;
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic       min_carry;
    logic [5:0] min_next;
    logic [4:0] hour_next;
    logic       alarm_fire;

    // Only a natural carry into the minute field can fire the alarm.
    assign min_carry  = ms_strobe & ~set_en & (ms == 10'd999) & (sec == 6'd59);
    assign min_next   = (min == 6'd59) ? 6'd0 : min + 6'd1;
    assign hour_next  = (min != 6'd59) ? hour :
                        (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    assign alarm_fire = min_carry && (min_next == alarm_min) && (hour_next == alarm_hour);

    // Alarm flag: set on match, cleared by an ack with no timer irq pending.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            alarm_irq <= 1'b0;
        end else if (alarm_fire) begin
            alarm_irq <= 1'b1;
        end else if (tmr_ack && !tmr_irq) begin
            alarm_irq <= 1'b0;
        end
    end
`else
    logic unused_alarm;

    assign unused_alarm = ^{alarm_hour, alarm_min};
    assign alarm_irq    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_timekeeper
// Description : Directed self-checking bench for rtc_timekeeper
//               (TICKS_PER_MS = 1, TMR_W = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_timekeeper;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        hold = 1'b0;
    logic        set_en = 1'b0;
    logic [4:0]  set_hour = '0;
    logic [5:0]  set_min = '0;
    logic [5:0]  set_sec = '0;
    logic        tmr_load = 1'b0;
    logic [15:0] tmr_val = '0;
    logic        tmr_stop = 1'b0;
    logic        tmr_ack = 1'b0;
    logic [4:0]  alarm_hour = 5'd31;
    logic [5:0]  alarm_min = 6'd63;
    logic [9:0]  ms;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic        day_wrap;
    logic [15:0] tmr_count;
    logic        tmr_busy;
    logic        tmr_irq;
    logic        alarm_irq;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_timekeeper #(.TICKS_PER_MS(1), .TMR_W(16)) dut (
        .clkin(clkin), .rst_n(rst_n), .tick_in(tick_in), .hold(hold),
        .set_en(set_en), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .tmr_load(tmr_load), .tmr_val(tmr_val), .tmr_stop(tmr_stop), .tmr_ack(tmr_ack),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .ms(ms), .sec(sec), .min(min), .hour(hour), .day_wrap(day_wrap),
        .tmr_count(tmr_count), .tmr_busy(tmr_busy), .tmr_irq(tmr_irq),
        .alarm_irq(alarm_irq)
    );

    always #5 clkin = ~clkin;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One tick_in rising edge; returns at a negedge after it took effect.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clkin) tick_in = 1'b1;
            @(negedge clkin) tick_in = 1'b0;
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clkin) begin set_en = 1'b1; set_hour = h; set_min = m; set_sec = s; end
        @(negedge clkin) set_en = 1'b0;
    endtask

    task automatic load_timer(input logic [15:0] v);
        @(negedge clkin) begin tmr_load = 1'b1; tmr_val = v; end
        @(negedge clkin) tmr_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clkin) rst_n = 1'b0;
        @(negedge clkin);
        @(negedge clkin) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({ms, sec, min, hour, day_wrap} !== 28'd0) begin n_fail++;
            $display("FAIL reset_time: got %0d:%0d:%0d.%0d wrap=%b want 0:0:0.0 wrap=0", hour, min, sec, ms, day_wrap); end
        n_checks++; if ({tmr_count, tmr_busy, tmr_irq, alarm_irq} !== 19'd0) begin n_fail++;
            $display("FAIL reset_timer: got cnt=%0d busy=%b irq=%b alarm=%b want all 0", tmr_count, tmr_busy, tmr_irq, alarm_irq); end
    endtask

    task automatic test_count();
        tick(1000);
        n_checks++; if (ms !== 10'd0 || sec !== 6'd1) begin n_fail++;
            $display("FAIL count_1000: got sec=%0d ms=%0d want sec=1 ms=0", sec, ms); end
        @(negedge clkin) tick_in = 1'b1;
        repeat (10) @(negedge clkin);
        tick_in = 1'b0;
        @(negedge clkin);
        n_checks++; if (ms !== 10'd1 || sec !== 6'd1) begin n_fail++;
            $display("FAIL long_pulse: got sec=%0d ms=%0d want sec=1 ms=1", sec, ms); end
    endtask

    task automatic test_set_wrap();
        set_time(5'd23, 6'd59, 6'd59);
        n_checks++; if ({hour, min, sec, ms} !== {5'd23, 6'd59, 6'd59, 10'd0}) begin n_fail++;
            $display("FAIL set_load: got %0d:%0d:%0d.%0d want 23:59:59.0", hour, min, sec, ms); end
        tick(999);
        n_checks++; if (ms !== 10'd999 || day_wrap !== 1'b0) begin n_fail++;
            $display("FAIL pre_wrap: got ms=%0d wrap=%b want ms=999 wrap=0", ms, day_wrap); end
        @(negedge clkin) tick_in = 1'b1;
        @(negedge clkin);
        n_checks++; if ({hour, min, sec, ms} !== 27'd0 || day_wrap !== 1'b1) begin n_fail++;
            $display("FAIL wrap: got %0d:%0d:%0d.%0d wrap=%b want 0:0:0.0 wrap=1", hour, min, sec, ms, day_wrap); end
        tick_in = 1'b0;
        @(negedge clkin);
        n_checks++; if (day_wrap !== 1'b0) begin n_fail++;
            $display("FAIL wrap_pulse: got wrap=%b one cycle later want 0", day_wrap); end
        set_time(5'd10, 6'd60, 6'd30);
        n_checks++; if ({hour, min, sec} !== {5'd10, 6'd0, 6'd30}) begin n_fail++;
            $display("FAIL set_clamp: got %0d:%0d:%0d want 10:0:30", hour, min, sec); end
    endtask

    task automatic test_timer_basic();
        load_timer(16'd3);
        n_checks++; if (tmr_count !== 16'd3 || tmr_busy !== 1'b1 || tmr_irq !== 1'b0) begin n_fail++;
            $display("FAIL tmr_load3: got cnt=%0d busy=%b irq=%b want 3/1/0", tmr_count, tmr_busy, tmr_irq); end
        for (int k = 2; k >= 0; k--) begin
            tick(1);
            n_checks++; if (tmr_count !== 16'(k)) begin n_fail++;
                $display("FAIL tmr_dec: got cnt=%0d want %0d", tmr_count, k); end
        end
        n_checks++; if (tmr_irq !== 1'b1 || tmr_busy !== 1'b0) begin n_fail++;
            $display("FAIL tmr_expire: got irq=%b busy=%b want 1/0", tmr_irq, tmr_busy); end
        @(negedge clkin) tmr_ack = 1'b1;
        @(negedge clkin) tmr_ack = 1'b0;
        n_checks++; if (tmr_irq !== 1'b0 || tmr_busy !== 1'b0) begin n_fail++;
            $display("FAIL tmr_ack: got irq=%b busy=%b want 0/0", tmr_irq, tmr_busy); end
        tick(2);
        n_checks++; if (tmr_count !== 16'd0 || tmr_irq !== 1'b0) begin n_fail++;
            $display("FAIL tmr_idle: got cnt=%0d irq=%b want 0/0", tmr_count, tmr_irq); end
    endtask

    task automatic test_timer_zero();
        load_timer(16'd0);
        n_checks++; if (tmr_irq !== 1'b1 || tmr_busy !== 1'b0 || tmr_count !== 16'd0) begin n_fail++;
            $display("FAIL tmr_zero: got irq=%b busy=%b cnt=%0d want 1/0/0", tmr_irq, tmr_busy, tmr_count); end
        @(negedge clkin) begin tmr_load = 1'b1; tmr_val = 16'd5; tmr_ack = 1'b1; end
        @(negedge clkin) begin tmr_load = 1'b0; tmr_ack = 1'b0; end
        n_checks++; if (tmr_count !== 16'd5 || tmr_busy !== 1'b1 || tmr_irq !== 1'b0) begin n_fail++;
            $display("FAIL tmr_load_ack: got cnt=%0d busy=%b irq=%b want 5/1/0", tmr_count, tmr_busy, tmr_irq); end
    endtask

    task automatic test_stop_hold();
        logic [9:0] ms_snap;
        load_timer(16'd10);
        tick(4);
        n_checks++; if (tmr_count !== 16'd6) begin n_fail++;
            $display("FAIL tmr_run4: got cnt=%0d want 6", tmr_count); end
        @(negedge clkin) tmr_stop = 1'b1;
        @(negedge clkin) tmr_stop = 1'b0;
        tick(5);
        n_checks++; if (tmr_count !== 16'd6 || tmr_busy !== 1'b0) begin n_fail++;
            $display("FAIL tmr_stop: got cnt=%0d busy=%b want 6/0", tmr_count, tmr_busy); end
        load_timer(16'd10);
        ms_snap = ms;
        @(negedge clkin) hold = 1'b1;
        tick(20);
        n_checks++; if (ms !== ms_snap || tmr_count !== 16'd10) begin n_fail++;
            $display("FAIL hold: got ms=%0d cnt=%0d want ms=%0d cnt=10", ms, tmr_count, ms_snap); end
        @(negedge clkin) hold = 1'b0;
        tick(2);
        n_checks++; if (ms !== ms_snap + 10'd2 || tmr_count !== 16'd8) begin n_fail++;
            $display("FAIL unhold: got ms=%0d cnt=%0d want ms=%0d cnt=8", ms, tmr_count, ms_snap + 10'd2); end
        do_reset();
        n_checks++; if ({ms, sec, min, hour, day_wrap, tmr_count, tmr_busy, tmr_irq, alarm_irq} !== 47'd0) begin n_fail++;
            $display("FAIL reset_midrun: got %0d:%0d:%0d.%0d cnt=%0d busy=%b irq=%b want all 0",
                     hour, min, sec, ms, tmr_count, tmr_busy, tmr_irq); end
    endtask

    task automatic test_alarm();
        logic exp_alarm;
`ifdef RTC_ALARM_EN
        exp_alarm = 1'b1;
`else
        exp_alarm = 1'b0;
`endif
        alarm_hour = 5'd0;
        alarm_min  = 6'd1;
        set_time(5'd0, 6'd0, 6'd59);
        n_checks++; if (alarm_irq !== 1'b0) begin n_fail++;
            $display("FAIL alarm_set: got alarm=%b after set_en want 0", alarm_irq); end
        tick(1000);
        n_checks++; if (alarm_irq !== exp_alarm || min !== 6'd1 || sec !== 6'd0) begin n_fail++;
            $display("FAIL alarm_match: got alarm=%b min=%0d sec=%0d want alarm=%b min=1 sec=0",
                     alarm_irq, min, sec, exp_alarm); end
        @(negedge clkin) tmr_ack = 1'b1;
        @(negedge clkin) tmr_ack = 1'b0;
        n_checks++; if (alarm_irq !== 1'b0) begin n_fail++;
            $display("FAIL alarm_clear: got alarm=%b want 0", alarm_irq); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_set_wrap();
        test_timer_basic();
        test_timer_zero();
        test_stop_hold();
        test_alarm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
- Consumes the 1 kHz square wave from the divided-clock generator and turns it into wall time and a countdown timer for the system.
- Runs entirely in the clkin domain.
- Detects rising edges of tick_in and prescales them to a 1 ms strobe.
- Keeps hh:mm:ss.mmm and a 16-bit millisecond countdown timer with a level interrupt and an ack handshake for the CPU/bus side.

Parameters:
- TICKS_PER_MS, 1, number of tick_in rising edges per millisecond (1..255).
- TMR_W, 16, countdown timer width in bits.

Ports:
- clkin  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- tick_in  in  1  divided clock from the generator; the rising edge is the event
- hold  in  1  freezes time and timer advance while high
- set_en  in  1  one-cycle strobe: load time fields
- set_hour  in  5  hour to load (0..23)
- set_min  in  6  minute to load (0..59)
- set_sec  in  6  second to load (0..59)
- tmr_load  in  1  one-cycle strobe: load the timer and start it
- tmr_val  in  TMR_W  timer load value in ms
- tmr_stop  in  1  one-cycle strobe: stop the timer
- tmr_ack  in  1  clears tmr_irq
- alarm_hour  in  5  alarm hour (used only with the optional feature)
- alarm_min  in  6  alarm minute (used only with the optional feature)
- ms  out  10  milliseconds, 0..999
- sec  out  6  seconds, 0..59
- min  out  6  minutes, 0..59
- hour  out  5  hours, 0..23
- day_wrap  out  1  one-cycle pulse when 23:59:59.999 rolls over to 0
- tmr_count  out  TMR_W  remaining timer ms
- tmr_busy  out  1  timer in RUN
- tmr_irq  out  1  level interrupt on expiry
- alarm_irq  out  1  alarm match flag

Behaviour:
- Reset: rst_n=0 at a clkin posedge clears every register and output to 0, tick_d=0, timer state IDLE. Reset takes priority over everything and aborts any countdown in progress.
- Edge detect: tick_d <= tick_in every cycle; rise = tick_in & ~tick_d. A level held high counts once.
- Prescaler pcnt (8 bit): on rise with hold=0, pcnt increments. On reaching TICKS_PER_MS-1 it returns to 0 and asserts ms_strobe that same cycle (combinational, internal).
- Outputs update on the same posedge where rise is sampled: 1 clkin latency after tick_in goes high.
- Time cascade on ms_strobe:
  - ms++; at 999 -> 0 and carry to sec.
  - sec 59 -> 0 carries to min; min 59 -> 0 carries to hour.
  - hour 23 -> 0 asserts day_wrap for exactly 1 cycle.
- hold=1: rise events are discarded, not queued; pcnt is held. Registered tick_d still tracks tick_in.
- set_en:
  - Loads hour/min/sec; clears ms and pcnt.
  - Each out-of-range field loads 0 (e.g. set_min=60 -> 0).
  - Beats a simultaneous ms_strobe: the strobe is lost and day_wrap is not asserted.
- Timer FSM, states IDLE, RUN, EXPIRED:
  - tmr_load from any state: tmr_count <= tmr_val and tmr_irq <= 0. Next state is RUN if tmr_val != 0, else EXPIRED with tmr_irq <= 1 on the same edge.
  - RUN: on each ms_strobe, tmr_count--. When tmr_count==1 and ms_strobe, it goes to 0, the FSM enters EXPIRED and tmr_irq <= 1.
  - tmr_stop in RUN: go to IDLE and hold tmr_count. tmr_stop is ignored in IDLE/EXPIRED.
  - EXPIRED: tmr_irq stays 1 until tmr_ack; tmr_ack -> IDLE, tmr_irq <= 0.
  - Priority: tmr_load > tmr_stop > tmr_ack > ms_strobe decrement.
  - tmr_ack while in RUN/IDLE is a no-op.
- tmr_busy = (state==RUN), registered.
- hold=1 also freezes the timer countdown; load, stop and ack still act.

Optional Feature:
- RTC_ALARM_EN defined: on the cycle where hour/min become equal to alarm_hour/alarm_min via a carry into min (sec 59->0), alarm_irq <= 1.
  - Reaching the alarm time through set_en does not fire.
  - alarm_irq is cleared only by tmr_ack while tmr_irq=0, or by reset.
- RTC_ALARM_EN undefined: alarm_irq is constant 0 and the alarm inputs are unused.

Test Plan:
- Reset, TICKS_PER_MS=1, 1000 tick_in rising edges -> ms=0, sec=1; a single 10-cycle-high tick pulse -> ms advances by exactly 1.
- set_en with 23:59:59, then 1000 ticks -> hour=min=sec=ms=0 and day_wrap high for exactly 1 cycle; set_min=60 -> min=0.
- tmr_load tmr_val=3, then 3 ticks -> tmr_count 2,1,0; tmr_irq=1 and tmr_busy=0 after the 3rd tick; tmr_ack -> tmr_irq=0, state IDLE.
- tmr_load tmr_val=0 -> tmr_irq=1 on the next edge; tmr_load=5 together with tmr_ack -> tmr_count=5, busy=1, irq=0.
- tmr_val=10, 4 ticks, tmr_stop -> count holds 6 over 5 more ticks; hold=1 during 20 ticks -> ms unchanged; rst_n=0 mid-RUN -> all outputs 0.
- With RTC_ALARM_EN, alarm 00:01: from 00:00:59, 1000 ticks -> alarm_irq=1. Without RTC_ALARM_EN, the same stimulus -> alarm_irq=0.
